f_fetch_stage: RTL and testbench

Y86-64 fetch stage sitting directly downstream of the F pipeline register. It consumes the F register's predicted PC and reads instruction bytes over a 64-bit aligned valid/ack instruction-memory port. It assembles unaligned 1–10 byte instructions, which may need two words, and splits them into fields. It computes valP and the next predicted PC, and presents the result to the D register with a valid/ready handshake. It also drives the F register's stall.

---
 rtl/f_fetch_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_f_fetch_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_stage.sv
// Y86-64 fetch stage: aligned 64-bit instruction fetch, two-word assembly, field split, PC prediction.
// Optional FETCH_LINE_BUF_EN: one-entry word buffer that satisfies repeat fetches of the same word.
//   state | meaning
//   IDLE  | post-reset, one cycle before the first request
//   REQ0  | fetching the word holding byte0
//   REQ1  | fetching the following word of a crossing instruction
//   VALID | decoded instruction held for the D register
//   DRAIN | flushed mid-request; waiting out the ack and discarding it
module f_fetch_stage (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [63:0] F_predPC_i,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic        imem_err_i,
    input  logic [63:0] imem_rdata_i,
    output logic        f_valid_o,
    input  logic        d_ready_i,
    output logic        F_stall_o,
    output logic [1:0]  f_stat_o,
    output logic [3:0]  f_icode_o,
    output logic [3:0]  f_ifun_o,
    output logic [3:0]  f_rA_o,
    output logic [3:0]  f_rB_o,
    output logic [63:0] f_valC_o,
    output logic [63:0] f_valP_o,
    output logic [63:0] f_predPC_o
);

    typedef enum logic [2:0] {S_IDLE, S_REQ0, S_REQ1, S_VALID, S_DRAIN} state_t;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] pc_q, word0_q;
    logic [1:0]  stat_q, stat_d;
    logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
    logic [63:0] valc_q, valc_d, valp_q, valp_d, pred_q, pred_d;
    logic        out_load, w0_load;

    logic        in_fetch, buf_hit, fetch_ack, fetch_err;
    logic [63:0] word0_addr, cur_addr, buf_data, fetch_data;

    assign in_fetch   = (state_q == S_REQ0) || (state_q == S_REQ1);
    assign word0_addr = {F_predPC_i[63:3], 3'b000};

    always_comb begin
        cur_addr = 64'h0;
        case (state_q)
            S_REQ0:          cur_addr = word0_addr;
            S_REQ1, S_DRAIN: cur_addr = addr_q;
            default:         cur_addr = 64'h0;
        endcase
    end

`ifdef FETCH_LINE_BUF_EN
    logic        buf_vld_q;
    logic [63:0] buf_addr_q, buf_data_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            buf_vld_q  <= 1'b0;
            buf_addr_q <= 64'h0;
            buf_data_q <= 64'h0;
        end else if (in_fetch && imem_ack_i && !buf_hit) begin
            if (imem_err_i) begin
                buf_vld_q <= 1'b0;
            end else begin
                buf_vld_q  <= 1'b1;
                buf_addr_q <= cur_addr;
                buf_data_q <= imem_rdata_i;
            end
        end
    end

    assign buf_hit  = in_fetch && buf_vld_q && (buf_addr_q == cur_addr);
    assign buf_data = buf_data_q;
`else
    assign buf_hit  = 1'b0;
    assign buf_data = 64'h0;
`endif

    assign fetch_ack   = in_fetch && (buf_hit || imem_ack_i);
    assign fetch_err   = !buf_hit && imem_err_i;
    assign fetch_data  = buf_hit ? buf_data : imem_rdata_i;
    assign imem_req_o  = (in_fetch && !buf_hit) || (state_q == S_DRAIN);
    assign imem_addr_o = cur_addr;

    // Decode works on a 16-byte window; in REQ0 only the low word is meaningful.
    logic [63:0]  dec_pc;
    logic [127:0] dec_line;
    logic [79:0]  instr;
    logic [3:0]   dec_icode, dec_ifun, dec_len;
    logic         bad_icode, bad_ifun, crosses;

    assign dec_pc    = (state_q == S_REQ1) ? pc_q : F_predPC_i;
    assign dec_line  = (state_q == S_REQ1) ? {fetch_data, word0_q} : {64'h0, fetch_data};
    assign instr     = 80'(dec_line >> {dec_pc[2:0], 3'b000});
    assign dec_icode = instr[7:4];
    assign dec_ifun  = instr[3:0];

    always_comb begin
        dec_len   = 4'd1;
        bad_icode = 1'b0;
        case (dec_icode)
            4'h0, 4'h1, 4'h9:       dec_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: dec_len = 4'd2;
            4'h3, 4'h4, 4'h5:       dec_len = 4'd10;
            4'h7, 4'h8:             dec_len = 4'd9;
            default:                bad_icode = 1'b1;
        endcase
    end

    assign bad_ifun = (dec_ifun != 4'h0) &&
                      !((dec_icode == 4'h2) || (dec_icode == 4'h6) || (dec_icode == 4'h7));
    assign crosses  = ({2'b00, dec_pc[2:0]} + {1'b0, dec_len}) > 5'd8;

    always_comb begin
        stat_d  = STAT_AOK;
        icode_d = dec_icode;
        ifun_d  = dec_ifun;
        ra_d    = (dec_len >= 4'd2) ? instr[15:12] : 4'hF;
        rb_d    = (dec_len >= 4'd2) ? instr[11:8]  : 4'hF;
        valc_d  = 64'h0;
        if (dec_len == 4'd9)  valc_d = instr[71:8];
        if (dec_len == 4'd10) valc_d = instr[79:16];
        valp_d  = dec_pc + {60'h0, dec_len};
        pred_d  = ((dec_icode == 4'h7) || (dec_icode == 4'h8)) ? valc_d : valp_d;
        if (bad_icode || bad_ifun) stat_d = STAT_INS;
        else if (dec_icode == 4'h0) stat_d = STAT_HLT;
        if (fetch_err) begin
            stat_d  = STAT_ADR;
            icode_d = 4'h1;
            ifun_d  = 4'h0;
            ra_d    = 4'h0;
            rb_d    = 4'h0;
            valc_d  = 64'h0;
            valp_d  = dec_pc;
            pred_d  = dec_pc;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        out_load = 1'b0;
        w0_load  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ0;
            S_REQ0: begin
                addr_d = word0_addr;
                if (flush_i) begin
                    state_d = fetch_ack ? S_REQ0 : S_DRAIN;
                end else if (fetch_ack) begin
                    if (!fetch_err && crosses) begin
                        w0_load = 1'b1;
                        addr_d  = word0_addr + 64'd8;
                        state_d = S_REQ1;
                    end else begin
                        out_load = 1'b1;
                        state_d  = S_VALID;
                    end
                end
            end
            S_REQ1: begin
                if (flush_i) begin
                    state_d = fetch_ack ? S_REQ0 : S_DRAIN;
                end else if (fetch_ack) begin
                    out_load = 1'b1;
                    state_d  = S_VALID;
                end
            end
            S_VALID: if (flush_i || d_ready_i) state_d = S_REQ0;
            S_DRAIN: if (!flush_i && imem_ack_i) state_d = S_REQ0;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= 64'h0;
            pc_q    <= 64'h0;
            word0_q <= 64'h0;
            stat_q  <= STAT_AOK;
            icode_q <= 4'h0;
            ifun_q  <= 4'h0;
            ra_q    <= 4'h0;
            rb_q    <= 4'h0;
            valc_q  <= 64'h0;
            valp_q  <= 64'h0;
            pred_q  <= 64'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            if (w0_load) begin
                pc_q    <= F_predPC_i;
                word0_q <= fetch_data;
            end
            if (out_load) begin
                stat_q  <= stat_d;
                icode_q <= icode_d;
                ifun_q  <= ifun_d;
                ra_q    <= ra_d;
                rb_q    <= rb_d;
                valc_q  <= valc_d;
                valp_q  <= valp_d;
                pred_q  <= pred_d;
            end
        end
    end

    assign f_valid_o  = (state_q == S_VALID);
    assign F_stall_o  = ~(f_valid_o & d_ready_i);
    assign f_stat_o   = stat_q;
    assign f_icode_o  = icode_q;
    assign f_ifun_o   = ifun_q;
    assign f_rA_o     = ra_q;
    assign f_rB_o     = rb_q;
    assign f_valC_o   = valc_q;
    assign f_valP_o   = valp_q;
    assign f_predPC_o = pred_q;

endmodule

// File: tb/tb_f_fetch_stage.sv
// Directed bench for f_fetch_stage: memory responder with programmable wait/fault, scoreboard of expected decodes.
module tb_f_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] F_predPC_i;
    logic        flush_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_ack_i;
    logic        imem_err_i;
    logic [63:0] imem_rdata_i;
    logic        f_valid_o;
    logic        d_ready_i;
    logic        F_stall_o;
    logic [1:0]  f_stat_o;
    logic [3:0]  f_icode_o, f_ifun_o, f_rA_o, f_rB_o;
    logic [63:0] f_valC_o, f_valP_o, f_predPC_o;

    always #5 clk = ~clk;

    f_fetch_stage dut (
        .clk_i(clk), .rst_n_i(rst_n), .F_predPC_i(F_predPC_i), .flush_i(flush_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
        .imem_err_i(imem_err_i), .imem_rdata_i(imem_rdata_i), .f_valid_o(f_valid_o),
        .d_ready_i(d_ready_i), .F_stall_o(F_stall_o), .f_stat_o(f_stat_o),
        .f_icode_o(f_icode_o), .f_ifun_o(f_ifun_o), .f_rA_o(f_rA_o), .f_rB_o(f_rB_o),
        .f_valC_o(f_valC_o), .f_valP_o(f_valP_o), .f_predPC_o(f_predPC_o)
    );

    typedef struct {
        logic [1:0]  stat;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp, pred;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] ack_q[$];
    logic [63:0] mem [0:63];
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    logic        err_en = 1'b0;
    logic [63:0] err_addr = 64'h0;
    int          tests = 0;
    int          fails = 0;

    // Memory responder: ack after wait_cfg idle request cycles, evaluated mid-cycle.
    always @(negedge clk) begin
        if (imem_req_o && rst_n && wait_cnt >= wait_cfg) begin
            imem_ack_i   = 1'b1;
            imem_rdata_i = mem[imem_addr_o[8:3]];
            imem_err_i   = err_en && (imem_addr_o == err_addr);
            wait_cnt     = 0;
            ack_q.push_back(imem_addr_o);
        end else begin
            imem_ack_i = 1'b0;
            imem_err_i = 1'b0;
            if (imem_req_o && rst_n) wait_cnt++;
            else wait_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                        input logic [63:0] vp, input logic [63:0] pp, input int lat);
        exp_t e;
        e.stat = st; e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
        e.valc = vc; e.valp = vp; e.pred = pp; e.lat = lat;
        sb.push_back(e);
    endtask

    // Called just after a clock edge that left the DUT in REQ0.
    task automatic fetch_expect(input string tag, input logic [63:0] next_pc, input int hold);
        exp_t e;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!f_valid_o && n < 60);
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".valid"}, f_valid_o, 1);
        chk({tag, ".latency"}, n - 1, e.lat);
        chk({tag, ".stat"}, f_stat_o, e.stat);
        chk({tag, ".icode"}, f_icode_o, e.icode);
        chk({tag, ".ifun"}, f_ifun_o, e.ifun);
        chk({tag, ".rA"}, f_rA_o, e.ra);
        chk({tag, ".rB"}, f_rB_o, e.rb);
        chk({tag, ".valC"}, f_valC_o, e.valc);
        chk({tag, ".valP"}, f_valP_o, e.valp);
        chk({tag, ".predPC"}, f_predPC_o, e.pred);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, ".hold_stall"}, F_stall_o, 1);
            chk({tag, ".hold_valid"}, f_valid_o, 1);
            chk({tag, ".hold_valC"}, f_valC_o, e.valc);
            chk({tag, ".hold_predPC"}, f_predPC_o, e.pred);
        end
        d_ready_i = 1'b1;
        #1;
        chk({tag, ".stall_release"}, F_stall_o, 0);
        @(posedge clk);
        #1;
        d_ready_i  = 1'b0;
        F_predPC_i = next_pc;
    endtask

    initial begin
        int n;
        int exp_reqs;
        rst_n = 1'b0; F_predPC_i = 64'h0; flush_i = 1'b0; d_ready_i = 1'b0;
        imem_ack_i = 1'b0; imem_err_i = 1'b0; imem_rdata_i = 64'h0;
        for (int i = 0; i < 64; i++) mem[i] = 64'h1010_1010_1010_1010;
        mem[0]  = 64'hF330_0000_0000_0120;
        mem[1]  = 64'h1122_3344_5566_7788;
        mem[2]  = 64'h0000_0000_0001_0080;
        mem[3]  = 64'h1010_1010_1010_1000;
        mem[5]  = 64'h1010_1010_1010_2361;
        mem[6]  = 64'h1010_1010_3010_1010;
        mem[7]  = 64'h1010_1010_1010_10C0;
        mem[8]  = 64'h1510_1010_1010_1000;
        mem[63] = 64'h10FF_FFFF_FFFF_FFFF;

        @(negedge clk);
        @(negedge clk);
        chk("rst.req", imem_req_o, 0);
        chk("rst.addr", imem_addr_o, 0);
        chk("rst.valid", f_valid_o, 0);
        chk("rst.stall", F_stall_o, 1);
        chk("rst.stat", f_stat_o, 0);
        chk("rst.predPC", f_predPC_o, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        push(2'd0, 4'h2, 4'h0, 4'h0, 4'h1, 64'h0, 64'h2, 64'h2, 1);
        fetch_expect("aligned", 64'h10, 0);

        wait_cfg = 1;
        ack_q.delete();
        push(2'd0, 4'h8, 4'h0, 4'h0, 4'h0, 64'h100, 64'h19, 64'h100, 4);
        fetch_expect("call", 64'h6, 3);
        chk("call.nreq", ack_q.size(), 2);
        chk("call.addr1", ack_q[1], 64'h18);

        wait_cfg = 0;
        ack_q.delete();
        push(2'd0, 4'h3, 4'h0, 4'hF, 4'h3, 64'h1122_3344_5566_7788, 64'h10, 64'h10, 2);
        fetch_expect("cross", 64'h20, 0);
        chk("cross.nreq", ack_q.size(), 2);
        chk("cross.addr0", ack_q[0], 64'h0);
        chk("cross.addr1", ack_q[1], 64'h8);

        wait_cfg = 2;
        ack_q.delete();
        @(negedge clk);
        chk("flush.req", imem_req_o, 1);
        chk("flush.addr", imem_addr_o, 64'h20);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i    = 1'b0;
        F_predPC_i = 64'h28;
        @(negedge clk);
        chk("drain.req", imem_req_o, 1);
        chk("drain.addr", imem_addr_o, 64'h20);
        @(negedge clk);
        chk("drain.req_ack", imem_req_o, 1);
        chk("drain.addr_ack", imem_addr_o, 64'h20);
        @(posedge clk);
        #1;
        push(2'd0, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h2A, 64'h2A, 3);
        fetch_expect("after_flush", 64'h33, 0);
        chk("flush.nreq", ack_q.size(), 2);
        chk("flush.newaddr", ack_q[1], 64'h28);

        wait_cfg = 0;
        err_en   = 1'b1;
        err_addr = 64'h30;
        push(2'd2, 4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 64'h33, 64'h33, 1);
        fetch_expect("adr", 64'h38, 0);
        err_en = 1'b0;

        push(2'd3, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h39, 64'h39, 1);
        fetch_expect("ins_icode", 64'h40, 0);
        push(2'd1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41, 64'h41, 1);
        fetch_expect("halt", 64'h47, 0);
        push(2'd3, 4'h1, 4'h5, 4'hF, 4'hF, 64'h0, 64'h48, 64'h48, 1);
        fetch_expect("ins_ifun", 64'hFFFF_FFFF_FFFF_FFFF, 0);
        push(2'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 1);
        fetch_expect("wrap", 64'h50, 0);

        ack_q.delete();
        push(2'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51, 64'h51, 1);
        fetch_expect("nop0", 64'h51, 0);
        push(2'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h52, 64'h52, 1);
        fetch_expect("nop1", 64'h60, 0);
`ifdef FETCH_LINE_BUF_EN
        exp_reqs = 1;
`else
        exp_reqs = 2;
`endif
        chk("linebuf.nreq", ack_q.size(), exp_reqs);

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!f_valid_o && n < 60);
        chk("vflush.valid_before", f_valid_o, 1);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i    = 1'b0;
        F_predPC_i = 64'h28;
        chk("vflush.valid_dropped", f_valid_o, 0);
        push(2'd0, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h2A, 64'h2A, 1);
        fetch_expect("vflush_next", 64'h70, 0);

        wait_cfg = 3;
        @(negedge clk);
        chk("midrst.req_before", imem_req_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.req", imem_req_o, 0);
        chk("midrst.addr", imem_addr_o, 0);
        chk("midrst.stall", F_stall_o, 1);
        chk("midrst.valP", f_valP_o, 0);
        chk("midrst.predPC", f_predPC_o, 0);
        wait_cfg   = 0;
        F_predPC_i = 64'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(2'd0, 4'h2, 4'h0, 4'h0, 4'h1, 64'h0, 64'h2, 64'h2, 1);
        fetch_expect("recover", 64'h2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
